// File: rtl/dma_dp_pkg.sv
// Shared types and default widths for the block-transfer DMA datapath.
package dma_dp_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned CPU_W      = 16;

  typedef enum logic [1:0] {
    SEL_SRC  = 2'd0,
    SEL_DST  = 2'd1,
    SEL_CNT  = 2'd2,
    SEL_STAT = 2'd3
  } cpu_sel_e;

endpackage

// File: rtl/dma_dp_if.sv
// Control strobes from the timing-and-control unit into the DMA datapath.
interface dma_dp_if;

  logic ProgramMode;
  logic StateRead;
  logic StateWrite;
  logic StateDone;
  logic ior;
  logic iow;

  modport tcu (
    output ProgramMode, StateRead, StateWrite, StateDone, ior, iow
  );

  modport dp (
    input ProgramMode, StateRead, StateWrite, StateDone, ior, iow
  );

endinterface

// File: rtl/dma_dp_counter.sv
// Loadable up/down counter; wrap_c flags that the next enabled step wraps.
module dma_dp_counter #(
  parameter int unsigned W  = 16,
  parameter bit          UP = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         wrap_c
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en) begin
      value <= UP ? value + W'(1) : value - W'(1);
    end
  end

  assign wrap_c = UP ? (&value) : (value == '0);

endmodule

// File: rtl/dma_block_dp.sv
// Block-transfer DMA datapath: programmed pointers/count, temp data register,
// transfer accounting and terminal count.
module dma_block_dp
  import dma_dp_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  dma_dp_if.dp              ctl,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_sel,
  input  logic [CPU_W-1:0]  cpu_wdata,
  output logic [CPU_W-1:0]  cpu_rdata,
  output logic [ADDR_W-1:0] addr_out,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              tc
);

  cpu_sel_e          sel;
  logic              is_wr;
  logic              is_rd;
  logic              xfer;
  logic              prog_wr;
  logic              iow_q;
  logic [DATA_W-1:0] temp;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [CNT_W-1:0]  cnt;
  logic              src_wrap;
  logic              dst_wrap;
  logic              cnt_zero;
  logic              unused_wrap;

  assign sel = cpu_sel_e'(cpu_sel);

  // Resolve control priority: ProgramMode > StateDone > StateWrite > StateRead.
  always_comb begin
    is_wr   = 1'b0;
    is_rd   = 1'b0;
    if (!ctl.ProgramMode && !ctl.StateDone) begin
      is_wr = ctl.StateWrite;
      is_rd = !ctl.StateWrite && ctl.StateRead;
    end
    xfer    = is_wr && ctl.iow && !iow_q;
    prog_wr = ctl.ProgramMode && cpu_we && (sel != SEL_STAT);
  end

  dma_dp_counter #(.W(ADDR_W), .UP(1'b1)) u_src (
    .clk      (clk),
    .reset    (reset),
    .load     (prog_wr && (sel == SEL_SRC)),
    .load_val (ADDR_W'(cpu_wdata)),
    .en       (xfer),
    .value    (src),
    .wrap_c   (src_wrap)
  );

  dma_dp_counter #(.W(ADDR_W), .UP(1'b1)) u_dst (
    .clk      (clk),
    .reset    (reset),
    .load     (prog_wr && (sel == SEL_DST)),
    .load_val (ADDR_W'(cpu_wdata)),
    .en       (xfer),
    .value    (dst),
    .wrap_c   (dst_wrap)
  );

  dma_dp_counter #(.W(CNT_W), .UP(1'b0)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (prog_wr && (sel == SEL_CNT)),
    .load_val (CNT_W'(cpu_wdata)),
    .en       (xfer),
    .value    (cnt),
    .wrap_c   (cnt_zero)
  );

  // Address pointers wrap silently; only the count wrap is architectural.
  assign unused_wrap = src_wrap ^ dst_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      iow_q <= 1'b0;
      tc    <= 1'b0;
      temp  <= '0;
    end else begin
      iow_q <= ctl.iow;
      if (prog_wr) begin
        tc <= 1'b0;
      end else if (xfer && cnt_zero) begin
        tc <= 1'b1;
      end
      if (is_rd && ctl.ior) begin
        temp <= data_in;
      end
    end
  end

  assign addr_out = is_wr ? dst : src;
  assign data_oe  = is_wr && ctl.iow;
  assign data_out = temp;

  always_comb begin
    cpu_rdata = '0;
    case (sel)
      SEL_SRC:  cpu_rdata = CPU_W'(src);
      SEL_DST:  cpu_rdata = CPU_W'(dst);
      SEL_CNT:  cpu_rdata = CPU_W'(cnt);
      SEL_STAT: cpu_rdata = CPU_W'(tc);
      default:  cpu_rdata = '0;
    endcase
  end

endmodule
